// File: rtl/maze_pkg.sv
// Shared constants and encodings for the maze player controller and its arbiter.
package maze_pkg;

    localparam int MAZE_WIDTH   = 30;
    localparam int MAZE_DEPTH   = 21;
    localparam int MAZE_START_X = 1;
    localparam int MAZE_START_Y = 1;
    localparam int MAZE_GOAL_X  = 28;
    localparam int MAZE_GOAL_Y  = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CHECK = 2'd2
    } CtrlState;

    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_D = 2'd1,
        DIR_L = 2'd2,
        DIR_R = 2'd3
    } MoveDir;

endpackage

// File: rtl/move_arbiter.sv
// Collapses the four move pulses into one request, favouring up, then down, then left, then right.
module move_arbiter
    import maze_pkg::*;
(
    input  logic   up,
    input  logic   down,
    input  logic   left,
    input  logic   right,
    output logic   valid,
    output MoveDir dir
);

    always_comb begin
        valid = up | down | left | right;
        dir   = DIR_R;
        if (up)
            dir = DIR_U;
        else if (down)
            dir = DIR_D;
        else if (left)
            dir = DIR_L;
    end

endmodule

// File: rtl/maze_player_ctrl.sv
// Player position controller: checks each requested step against the map ROM before committing it.
module maze_player_ctrl
    import maze_pkg::*;
#(
    parameter int WIDTH   = MAZE_WIDTH,
    parameter int DEPTH   = MAZE_DEPTH,
    parameter int START_X = MAZE_START_X,
    parameter int START_Y = MAZE_START_Y,
    parameter int GOAL_X  = MAZE_GOAL_X,
    parameter int GOAL_Y  = MAZE_GOAL_Y
)(
    input  logic             clk,
    input  logic             Reset,
    input  logic             btn_u,
    input  logic             btn_d,
    input  logic             btn_l,
    input  logic             btn_r,
    output logic [4:0]       rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic [4:0]       player_x,
    output logic [4:0]       player_y,
    output logic             busy,
    output logic             blocked,
    output logic             at_goal,
    output logic [15:0]      move_count
);

    CtrlState         state;
    CtrlState         nextState;
    logic             arbValid;
    MoveDir           arbDir;
    logic [5:0]       candX;
    logic [5:0]       candY;
    logic             inRange;
    logic             moveReq;
    logic [4:0]       targetX;
    logic [4:0]       targetY;
    logic [WIDTH-1:0] shiftedRow;
    logic             wallHit;

    move_arbiter arbiter (
        .up    (btn_u),
        .down  (btn_d),
        .left  (btn_l),
        .right (btn_r),
        .valid (arbValid),
        .dir   (arbDir)
    );

    // One extra bit lets a step below zero wrap high and fail the range compare.
    always_comb begin
        candX = {1'b0, player_x};
        candY = {1'b0, player_y};
        unique case (arbDir)
            DIR_U: candY = {1'b0, player_y} - 6'd1;
            DIR_D: candY = {1'b0, player_y} + 6'd1;
            DIR_L: candX = {1'b0, player_x} - 6'd1;
            DIR_R: candX = {1'b0, player_x} + 6'd1;
        endcase
        inRange = (candX < 6'(WIDTH)) && (candY < 6'(DEPTH));
        moveReq = (state == IDLE) && arbValid && !at_goal;
    end

    always_comb begin
        shiftedRow = rom_data << targetX;
        wallHit    = shiftedRow[WIDTH-1];
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (moveReq && inRange) nextState = READ;
            READ:    nextState = CHECK;
            CHECK:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        rom_addr = (state == READ) ? targetY : player_y;
        at_goal  = (player_x == 5'(GOAL_X)) && (player_y == 5'(GOAL_Y));
    end

    // Blocked is a one-cycle pulse raised either by an off-map target or by a wall hit.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            player_x   <= 5'(START_X);
            player_y   <= 5'(START_Y);
            targetX    <= '0;
            targetY    <= '0;
            blocked    <= 1'b0;
            move_count <= '0;
        end else begin
            blocked <= 1'b0;
            if (moveReq) begin
                if (inRange) begin
                    targetX <= candX[4:0];
                    targetY <= candY[4:0];
                end else begin
                    blocked <= 1'b1;
                end
            end
            if (state == CHECK) begin
                if (wallHit) begin
                    blocked <= 1'b1;
                end else begin
                    player_x <= targetX;
                    player_y <= targetY;
                    if (move_count != 16'hFFFF)
                        move_count <= move_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Randomised and directed bench for maze_player_ctrl against a coordinate-level player model.
module tb_maze_player_ctrl;

    localparam int W  = 30;
    localparam int D  = 21;
    localparam int SX = 1;
    localparam int SY = 1;
    localparam int GX = 28;
    localparam int GY = 19;

    logic         clk;
    logic         Reset;
    logic         btn_u, btn_d, btn_l, btn_r;
    logic [4:0]   rom_addr;
    logic [W-1:0] rom_data;
    logic [4:0]   player_x, player_y;
    logic         busy, blocked, at_goal;
    logic [15:0]  move_count;

    logic [W-1:0] mapMem [D];
    int vectors = 0;
    int miscompares = 0;
    int mx, my, mcount;

    maze_player_ctrl #(
        .WIDTH(W), .DEPTH(D), .START_X(SX), .START_Y(SY), .GOAL_X(GX), .GOAL_Y(GY)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .btn_u      (btn_u),
        .btn_d      (btn_d),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .player_x   (player_x),
        .player_y   (player_y),
        .busy       (busy),
        .blocked    (blocked),
        .at_goal    (at_goal),
        .move_count (move_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered map ROM as the integrating top would provide it.
    always @(posedge clk)
        rom_data <= (rom_addr < 5'(D)) ? mapMem[rom_addr] : '0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkPosition(input string tag);
        checkOutput({tag, ".x"}, 32'(player_x), 32'(mx));
        checkOutput({tag, ".y"}, 32'(player_y), 32'(my));
        checkOutput({tag, ".count"}, 32'(move_count), 32'(mcount));
        checkOutput({tag, ".goal"}, 32'(at_goal), 32'((mx == GX) && (my == GY)));
    endtask

    task automatic setButtons(input logic [3:0] b);
        {btn_u, btn_d, btn_l, btn_r} = b;
    endtask

    task automatic fillMap(input int mode);
        for (int r = 0; r < D; r++)
            mapMem[r] = (mode == 0) ? '0 : (W'($urandom) & W'($urandom));
    endtask

    task automatic resetDut();
        @(negedge clk);
        Reset = 1'b1;
        setButtons(4'b0000);
        @(negedge clk);
        Reset = 1'b0;
        mx = SX;
        my = SY;
        mcount = 0;
    endtask

    // btns = {u,d,l,r}; dropBtns are driven while the move is being evaluated and must be ignored.
    task automatic applyStimulus(input logic [3:0] btns, input logic [3:0] dropBtns);
        int tx, ty;
        bit act, inR, wall;
        @(negedge clk);
        setButtons(btns);
        act = (btns != 4'b0000) && !((mx == GX) && (my == GY));
        tx = mx;
        ty = my;
        if (btns[3])      ty = my - 1;
        else if (btns[2]) ty = my + 1;
        else if (btns[1]) tx = mx - 1;
        else if (btns[0]) tx = mx + 1;
        inR = (tx >= 0) && (tx < W) && (ty >= 0) && (ty < D);

        @(negedge clk);
        if (act && inR) begin
            checkOutput("read.busy", 32'(busy), 32'd1);
            checkOutput("read.addr", 32'(rom_addr), 32'(ty));
            checkOutput("read.blocked", 32'(blocked), 32'd0);
            setButtons(dropBtns);
            @(negedge clk);
            checkOutput("check.busy", 32'(busy), 32'd1);
            checkPosition("check");
            setButtons(4'b0000);
            @(negedge clk);
            wall = mapMem[ty][W-1-tx];
            if (!wall) begin
                mx = tx;
                my = ty;
                if (mcount < 65535) mcount++;
            end
            checkOutput("done.busy", 32'(busy), 32'd0);
            checkOutput("done.blocked", 32'(blocked), 32'(wall));
            checkPosition("done");
        end else begin
            setButtons(4'b0000);
            checkOutput("idle.busy", 32'(busy), 32'd0);
            checkOutput("idle.blocked", 32'(blocked), 32'(act));
            checkOutput("idle.addr", 32'(rom_addr), 32'(my));
            checkPosition("idle");
        end
        @(negedge clk);
        checkOutput("after.blocked", 32'(blocked), 32'd0);
        checkOutput("after.busy", 32'(busy), 32'd0);
        checkPosition("after");
    endtask

    initial begin
        Reset = 1'b1;
        setButtons(4'b0000);
        fillMap(1);
        mx = SX;
        my = SY;
        mcount = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset.addr", 32'(rom_addr), 32'(SY));
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.blocked", 32'(blocked), 32'd0);
        checkPosition("reset");
        Reset = 1'b0;

        // Wall above the start cell.
        mapMem[0] = '1;
        applyStimulus(4'b1000, 4'b0000);

        // Open corridor to the right, then back.
        mapMem[1][W-1-2] = 1'b0;
        applyStimulus(4'b0001, 4'b0000);
        mapMem[1][W-1-1] = 1'b0;
        applyStimulus(4'b0010, 4'b0000);

        // Up beats right; down during evaluation is dropped.
        mapMem[0][W-1-1] = 1'b0;
        mapMem[1][W-1-2] = 1'b0;
        applyStimulus(4'b1001, 4'b0100);

        // Into the corner, then off-map requests.
        mapMem[0][W-1-0] = 1'b0;
        applyStimulus(4'b0010, 4'b1111);
        applyStimulus(4'b0010, 4'b0000);
        applyStimulus(4'b1000, 4'b0000);
        applyStimulus(4'b0011, 4'b0000);

        // Reset during CHECK of an open move.
        resetDut();
        fillMap(0);
        applyStimulus(4'b0001, 4'b0000);
        @(negedge clk);
        setButtons(4'b0001);
        @(negedge clk);
        setButtons(4'b0000);
        checkOutput("midrst.read", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("midrst.check", 32'(busy), 32'd1);
        #2 Reset = 1'b1;
        #1;
        mx = SX;
        my = SY;
        mcount = 0;
        checkOutput("midrst.busy", 32'(busy), 32'd0);
        checkOutput("midrst.addr", 32'(rom_addr), 32'(SY));
        checkPosition("midrst");
        @(negedge clk);
        Reset = 1'b0;

        // Random walk over random maps.
        fillMap(1);
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) fillMap(1);
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Walk to the goal on an open map, then try to leave it.
        resetDut();
        fillMap(0);
        repeat (GX - SX) applyStimulus(4'b0001, 4'b0000);
        repeat (GY - SY) applyStimulus(4'b0100, 4'b0000);
        checkOutput("goal.reached", 32'(at_goal), 32'd1);
        repeat (3) applyStimulus(4'b0001, 4'b0000);
        applyStimulus(4'b1111, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
